alt_mem_ddrx_buffer_read_sequencer: RTL

//  Read-side sequencer for the controller write-data buffer. Accepts burst read requests from the

---
 rtl/alt_mem_ddrx_buffer_read_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alt_mem_ddrx_buffer_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alt_mem_ddrx_buffer_read_sequencer
// Brief    : Read-side sequencer for the controller write-data buffer. Accepts
//            burst read requests, tracks buffer occupancy from observed writes
//            and issues one read beat per cycle in strict circular order.
// Options  : ALT_MEM_DDRX_BUFREAD_ERR_CHECK_EN enables the sticky error flags
//            (err_occupancy_overflow, err_zero_burst); otherwise both read 0.
// Revision : 1.0 - initial release
// ============================================================================
module alt_mem_ddrx_buffer_read_sequencer #(
  parameter int CFG_BUFFER_ADDR_WIDTH = 6,
  parameter int CFG_BURSTCOUNT_WIDTH  = 4
) (
  input  logic                             ctl_clk,
  input  logic                             ctl_reset,
  input  logic                             buffwrite_valid,
  input  logic                             rdreq_valid,
  output logic                             rdreq_ready,
  input  logic [CFG_BURSTCOUNT_WIDTH-1:0]  rdreq_burstcount,
  output logic                             readif_valid,
  output logic [CFG_BUFFER_ADDR_WIDTH-1:0] readif_address,
  output logic                             readif_last,
  output logic                             burst_done,
  output logic [CFG_BUFFER_ADDR_WIDTH:0]   occupancy,
  output logic                             err_occupancy_overflow,
  output logic                             err_zero_burst
);

  localparam int AW  = CFG_BUFFER_ADDR_WIDTH;
  localparam int BCW = CFG_BURSTCOUNT_WIDTH;

  localparam logic [AW:0]    C_DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]    C_OCC_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]  C_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [BCW-1:0] C_REM_ONE = {{(BCW-1){1'b0}}, 1'b1};
  localparam logic [BCW-1:0] C_REM_ZERO = {BCW{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  state_t          state_q,     state_d;
  logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [AW:0]     occupancy_q, occupancy_d;
  logic [BCW-1:0]  remaining_q, remaining_d;
  logic            burst_done_q, burst_done_d;

  logic            w_accept;
  logic            w_zero_burst;

  // Beat issue and handshake are decoded from registered state only, so a
  // same-cycle buffer write can never enable a beat.
  always_comb begin
    readif_valid   = (state_q == ST_READ) && (occupancy_q != '0);
    readif_last    = (state_q == ST_READ) && (remaining_q == C_REM_ONE);
    readif_address = rd_ptr_q;
    rdreq_ready    = (state_q == ST_IDLE) || (readif_valid && readif_last);
    w_accept       = rdreq_valid && rdreq_ready;
    w_zero_burst   = w_accept && (rdreq_burstcount == C_REM_ZERO);
  end

  // Next-state logic: burst sequencing, read pointer and completion pulse.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    remaining_d  = remaining_q;
    burst_done_d = readif_valid && readif_last;

    case (state_q)
      ST_IDLE: begin
        if (w_accept && !w_zero_burst) begin
          remaining_d = rdreq_burstcount;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (readif_valid) begin
          rd_ptr_d    = rd_ptr_q + C_PTR_ONE;
          remaining_d = remaining_q - C_REM_ONE;
          if (readif_last) begin
            // A request taken on the last beat chains on with no bubble.
            if (w_accept && !w_zero_burst) begin
              remaining_d = rdreq_burstcount;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Occupancy: writes add, issued beats subtract; saturates at full depth.
  always_comb begin
    occupancy_d = occupancy_q;
    if (buffwrite_valid && !readif_valid) begin
      if (occupancy_q != C_DEPTH) begin
        occupancy_d = occupancy_q + C_OCC_ONE;
      end
    end else if (!buffwrite_valid && readif_valid) begin
      occupancy_d = occupancy_q - C_OCC_ONE;
    end
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge ctl_clk) begin
    if (ctl_reset) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= '0;
      occupancy_q  <= '0;
      remaining_q  <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      occupancy_q  <= occupancy_d;
      remaining_q  <= remaining_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign occupancy  = occupancy_q;
  assign burst_done = burst_done_q;

`ifdef ALT_MEM_DDRX_BUFREAD_ERR_CHECK_EN
  logic err_ovf_q,  err_ovf_d;
  logic err_zero_q, err_zero_d;

  // Sticky error flags: set on the offending event, cleared only by reset.
  always_comb begin
    err_ovf_d  = err_ovf_q  || (buffwrite_valid && (occupancy_q == C_DEPTH));
    err_zero_d = err_zero_q || w_zero_burst;
  end

  // Error flag registers.
  always_ff @(posedge ctl_clk) begin
    if (ctl_reset) begin
      err_ovf_q  <= 1'b0;
      err_zero_q <= 1'b0;
    end else begin
      err_ovf_q  <= err_ovf_d;
      err_zero_q <= err_zero_d;
    end
  end

  assign err_occupancy_overflow = err_ovf_q;
  assign err_zero_burst         = err_zero_q;
`else
  assign err_occupancy_overflow = 1'b0;
  assign err_zero_burst         = 1'b0;
`endif

endmodule
`default_nettype wire
